// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Unsigned N x N shift-and-add multiplier that borrows an external shared
//   ALU, issuing one ALU operation per clock (add / shift right / shift left).
//   Early exit happens as soon as the shifted multiplier reaches zero.
//   Overflow is flagged when a set multiplicand bit has been shifted out
//   before a later add, or when an add carries out of the accumulator.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_start, i_a, i_b   request + operands, accepted only while o_ready=1
//   o_ready             1 in IDLE
//   o_busy              1 while sequencing the ALU (ADD/SHR/SHL)
//   o_done              one-cycle pulse, o_product/o_ovf valid
//   o_product, o_ovf    low N bits of a*b and overflow flag, held until next accept
//   o_alu_a/b/ctrl      ALU operands and opcode (decoded from registered state)
//   i_alu_q/zero/mayor  ALU result, zero flag, carry-out of add
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_product,
    output logic         o_ovf,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [2:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_q,
    input  logic         i_alu_zero,
    input  logic         i_alu_mayor
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHR,
        S_SHL,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_mcand;
    logic [N-1:0] r_mplier;
    logic         r_lost;   // a set multiplicand bit has been shifted out
    logic         r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_lost   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_lost   <= 1'b0;
                        if (i_b == '0)
                            r_state <= S_DONE;
                        else if (i_b[0])
                            r_state <= S_ADD;
                        else
                            r_state <= S_SHR;
                    end
                end
                S_ADD: begin
                    r_acc <= i_alu_q;
                    // A lost multiplicand bit only matters once it would
                    // have been added, so it is folded into ovf here.
                    if (i_alu_mayor || r_lost)
                        r_ovf <= 1'b1;
                    r_state <= S_SHR;
                end
                S_SHR: begin
                    r_mplier <= i_alu_q;
                    r_state  <= i_alu_zero ? S_DONE : S_SHL;
                end
                S_SHL: begin
                    r_mcand <= i_alu_q;
                    r_lost  <= r_lost | r_mcand[N-1];
                    // r_mplier already holds the shifted value from SHR
                    r_state <= r_mplier[0] ? S_ADD : S_SHR;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU drive is decoded from registered state only; no path from i_alu_*.
    always_comb begin
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_ctrl = OP_PASSB;
        case (r_state)
            S_ADD: begin
                o_alu_a    = r_acc;
                o_alu_b    = r_mcand;
                o_alu_ctrl = OP_ADD;
            end
            S_SHR: begin
                o_alu_a    = r_mplier;
                o_alu_ctrl = OP_SHR;
            end
            S_SHL: begin
                o_alu_a    = r_mcand;
                o_alu_ctrl = OP_SHL;
            end
            default: begin
                o_alu_a    = '0;
                o_alu_b    = '0;
                o_alu_ctrl = OP_PASSB;
            end
        endcase
    end

    assign o_ready   = (r_state == S_IDLE);
    assign o_busy    = (r_state == S_ADD) || (r_state == S_SHR) || (r_state == S_SHL);
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_acc;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//   Directed bench for alu_mul_seq. A behavioural ALU closes the loop around
//   the DUT; expected products, flags and latencies are hand-computed.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a, b;
    logic         ready, busy, done, ovf;
    logic [N-1:0] product;
    logic [N-1:0] alu_a, alu_b, alu_q;
    logic [2:0]   alu_ctrl;
    logic         alu_zero, alu_carry;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mul_seq #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_a         (a),
        .i_b         (b),
        .o_ready     (ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_product   (product),
        .o_ovf       (ovf),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_ctrl  (alu_ctrl),
        .i_alu_q     (alu_q),
        .i_alu_zero  (alu_zero),
        .i_alu_mayor (alu_carry)
    );

    // Behavioural shared ALU
    always_comb begin
        alu_q     = '0;
        alu_carry = 1'b0;
        case (alu_ctrl)
            3'b000:  {alu_carry, alu_q} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_q = alu_a >> 1;
            3'b011:  alu_q = alu_a << 1;
            3'b100:  alu_q = alu_b;
            default: alu_q = '0;
        endcase
        alu_zero = (alu_q == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for o_done; cyc = edges from accept to DONE.
    task automatic run_mul(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                           output int cyc, output logic timed_out);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = !done;
    endtask

    task automatic check_mul(input string name, input logic [N-1:0] ta,
                             input logic [N-1:0] tb_, input logic [N-1:0] exp_p,
                             input logic exp_o, input int exp_cyc);
        int   cyc;
        logic to;
        run_mul(ta, tb_, cyc, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s: timeout, no o_done", name);
        end else begin
            if (product !== exp_p) begin
                n_fail++;
                $display("FAIL %s product: got %h want %h", name, product, exp_p);
            end
            n_tests++;
            if (ovf !== exp_o) begin
                n_fail++;
                $display("FAIL %s ovf: got %b want %b", name, ovf, exp_o);
            end
            if (exp_cyc > 0) begin
                n_tests++;
                if (cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ready, busy, done, ovf, product} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset state: got rdy=%b busy=%b done=%b ovf=%b p=%h want 1 0 0 0 0000",
                     ready, busy, done, ovf, product);
        end
        n_tests++;
        if ({alu_ctrl, alu_a, alu_b} !== {3'b100, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset alu drive: got ctrl=%b a=%h b=%h want 100 0000 0000",
                     alu_ctrl, alu_a, alu_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        check_mul("3x5", 16'd3, 16'd5, 16'd15, 1'b0, 8);
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || product !== 16'd15) begin
            n_fail++;
            $display("FAIL 3x5 hold: got rdy=%b p=%h want 1 000f", ready, product);
        end
        check_mul("7x6", 16'd7, 16'd6, 16'd42, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_zero_mult;
        check_mul("1234x0", 16'h1234, 16'h0000, 16'h0000, 1'b0, 1);
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero ready-after-done: got rdy=%b done=%b want 1 0", ready, done);
        end
    endtask

    task automatic test_ovf;
        check_mul("00ffx0101", 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 0);
        @(negedge clk);
        check_mul("ffffx3", 16'hFFFF, 16'h0003, 16'hFFFD, 1'b1, 0);
        @(negedge clk);
        check_mul("8000x3", 16'h8000, 16'h0003, 16'h8000, 1'b1, 0);
        @(negedge clk);
        // ovf must clear on the next accept
        check_mul("2x2", 16'd2, 16'd2, 16'd4, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_max;
        check_mul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 48);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cnt;
        @(negedge clk);
        start = 1'b1; a = 16'd3; b = 16'd5;
        @(negedge clk);
        a = 16'd7; b = 16'd9;   // start stays high with new operands
        cnt = 1;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (!done || product !== 16'd15 || cnt != 8) begin
            n_fail++;
            $display("FAIL b2b first: got done=%b p=%h cyc=%0d want 1 000f 8", done, product, cnt);
        end
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || product !== 16'd15) begin
            n_fail++;
            $display("FAIL b2b idle: got rdy=%b p=%h want 1 000f", ready, product);
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b accept-in-idle: got busy=%b want 1", busy);
        end
        cnt = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (!done || product !== 16'd63) begin
            n_fail++;
            $display("FAIL b2b second: got done=%b p=%h want 1 003f", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cnt;
        int seen_done;
        @(negedge clk);
        start = 1'b1; a = 16'h00FF; b = 16'h00FF;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (alu_ctrl !== 3'b011 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (alu_ctrl !== 3'b011) begin
            n_fail++;
            $display("FAIL midreset: never reached SHL, ctrl=%b", alu_ctrl);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ready, busy, done, ovf, product} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL midreset outputs: got rdy=%b busy=%b done=%b ovf=%b p=%h want 1 0 0 0 0000",
                     ready, busy, done, ovf, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_tests++;
        if (seen_done != 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset no-done: got done_count=%0d rdy=%b want 0 1", seen_done, ready);
        end
        check_mul("7x6 after reset", 16'd7, 16'd6, 16'd42, 1'b0, 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_mult;
        test_ovf;
        test_max;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
